prog_clk_div: RTL

Runtime-programmable clock divider producing a 50 %-duty slow clock (`ClkOut`) and a one-cycle rising-edge strobe (`Tick`) from the system clock. It generalises the fixed-constant level divider: counter width and level count are parameters, the divide table is writable at runtime, and rate changes are applied glitch-free at period boundaries instead of restarting the output mid-period. It sits between the level/score logic and the display/game-speed logic that consumes the slow clock.

---
 rtl/prog_clk_div.sv | 114 +++++++++++
 1 files changed

// File: rtl/prog_clk_div.sv
// prog_clk_div: runtime-programmable 50%-duty clock divider with a rising-edge
// strobe. Divide values live in a writable table indexed by a registered level
// select; a new rate takes effect only at the end of a full output period, so
// the divided clock never shows a shortened or stretched phase while running.
module prog_clk_div #(
  parameter int unsigned CNT_W   = 29,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned DEF_DIV = 50000000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [SEL_W-1:0] Sel,
  input  logic             WrEn,
  input  logic [SEL_W-1:0] WrAddr,
  input  logic [CNT_W-1:0] WrData,
  output logic             ClkOut,
  output logic             Tick,
  output logic             Pending
);

  localparam int unsigned      DEPTH   = 2 ** SEL_W;
  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

  // Output phase of the divided clock; PH_HIGH drives ClkOut high.
  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  logic [CNT_W-1:0] tbl [DEPTH];
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] div_sel;
  logic [CNT_W-1:0] div_cnt;
  phase_t           phase;
  logic             tick_q;

  logic [CNT_W-1:0] div_sel_nxt;
  logic [CNT_W-1:0] div_cnt_nxt;
  phase_t           phase_nxt;
  logic             tick_nxt;
  logic [CNT_W-1:0] target;
  logic             at_end;

  // Divide value requested by the currently registered level.
  assign target  = tbl[sel_q];
  // Last cycle of the current half period.
  assign at_end  = (div_cnt == div_sel);

  assign ClkOut  = (phase == PH_HIGH);
  assign Tick    = tick_q;
  assign Pending = (target != div_sel);

  // Divide table: reloaded with the default on reset, otherwise written on WrEn.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[i] <= DEF_VAL;
      end
    end else if (WrEn) begin
      tbl[WrAddr] <= WrData;
    end
  end

  // Level select register, sampled every cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sel_q <= '0;
    end else begin
      sel_q <= Sel;
    end
  end

  // Divider state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      phase   <= PH_LOW;
      div_cnt <= '0;
      div_sel <= DEF_VAL;
      tick_q  <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      div_cnt <= div_cnt_nxt;
      div_sel <= div_sel_nxt;
      tick_q  <= tick_nxt;
    end
  end

  // Next-state: count half periods, toggle the phase, and only reload the
  // active divide value when a high phase ends (or freely while idle).
  always_comb begin
    phase_nxt   = phase;
    div_cnt_nxt = div_cnt;
    div_sel_nxt = div_sel;
    tick_nxt    = 1'b0;
    if (!En) begin
      phase_nxt   = PH_LOW;
      div_cnt_nxt = '0;
      div_sel_nxt = target;
    end else if (at_end) begin
      div_cnt_nxt = '0;
      if (phase == PH_HIGH) begin
        phase_nxt   = PH_LOW;
        div_sel_nxt = target;
      end else begin
        phase_nxt = PH_HIGH;
        tick_nxt  = 1'b1;
      end
    end else begin
      div_cnt_nxt = div_cnt + CNT_W'(1);
    end
  end

endmodule
